// File: rtl/cla_seq_addsub.sv
// Multi-cycle add/subtract unit: one 4-bit carry-lookahead slice per cycle,
// carry chained through a register, registered result with {z,n,v,c} flags.
module cla_seq_addsub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [3:0]       cc,
   output logic             busy
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IW     = $clog2(NSLICE);
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh, work;
   logic             sub_r, carry, c_msb;
   logic [IW-1:0]    idx;
   logic [5:0]       slice;   // {c4, c3, s[3:0]}

   // 4-bit lookahead: every carry is a flat sum-of-products of g/p and cin.
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic cin);
      logic [3:0] g, p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return {c[4], c[3], p ^ c[3:0]};
   endfunction

   always_comb slice = cla4(a_sh[3:0], b_sh[3:0] ^ {4{sub_r}}, carry);

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // NOTE: all state here is sequential, so every assignment is non-blocking;
   // blocking assignments would let later statements see same-edge updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         work      <= '0;
         sub_r     <= 1'b0;
         carry     <= 1'b0;
         c_msb     <= 1'b0;
         idx       <= '0;
         sum       <= '0;
         cc        <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  sub_r <= sub;
                  carry <= sub;
                  idx   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               // Operands shift down so the active slice is always bits [3:0];
               // result nibbles enter at the top and land in place after NSLICE steps.
               a_sh  <= a_sh >> 4;
               b_sh  <= b_sh >> 4;
               work  <= {slice[3:0], work[WIDTH-1:4]};
               carry <= slice[5];
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  c_msb <= slice[4];
                  state <= DONE;
               end
            end
            DONE: begin
               if (!out_valid) begin
                  sum       <= work;
                  cc        <= {(work == '0), work[WIDTH-1], c_msb ^ carry, carry};
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_addsub.sv
// Directed bench for cla_seq_addsub (WIDTH=16): scoreboard of reference results,
// latency, backpressure and mid-calculation reset checks.
module tb_cla_seq_addsub;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [15:0] a, b;
   logic        sub;
   logic        out_valid, out_ready;
   logic [15:0] sum;
   logic [3:0]  cc;
   logic        busy;

   int tests = 0;
   int fails = 0;
   logic [19:0] sb[$];   // {cc, sum}

   cla_seq_addsub #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cc(cc), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic s);
      logic [15:0] ys;
      logic [16:0] full;
      logic        v;
      ys   = y ^ {16{s}};
      full = {1'b0, x} + {1'b0, ys} + 17'(s);
      v    = (x[15] == ys[15]) && (full[15] != x[15]);
      return {(full[15:0] == 16'h0), full[15], v, full[16], full[15:0]};
   endfunction

   // Drive one operation from a negedge; hold the result for 'stall' cycles
   // while poking in_valid, then hand it over.
   task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic s, input int stall);
      logic [19:0] exp;
      int cyc;
      check({tag, "_in_ready"}, in_ready, 1'b1);
      sb.push_back(model(x, y, s));
      in_valid = 1'b1; a = x; b = y; sub = s;
      @(negedge clk);
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~s;
      check({tag, "_busy"}, busy, 1'b1);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, cyc, 5);
      exp = sb.pop_front();
      check({tag, "_sum"}, sum, exp[15:0]);
      check({tag, "_cc"}, cc, exp[19:16]);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
         @(negedge clk);
         check({tag, "_stall_valid"}, out_valid, 1'b1);
         check({tag, "_stall_ready"}, in_ready, 1'b0);
         check({tag, "_stall_sum"}, sum, exp[15:0]);
         check({tag, "_stall_cc"}, cc, exp[19:16]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_handover"}, out_valid, 1'b0);
      check({tag, "_retain"}, {cc, sum}, exp);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", sum, 16'h0);
      check("rst_cc", cc, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      do_op("add_5555", 16'h1234, 16'h4321, 1'b0, 0);
      do_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 0);
      do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 0);
      do_op("sub_neg",  16'h0003, 16'h0005, 1'b1, 0);
      do_op("sub_zero", 16'h0005, 16'h0005, 1'b1, 0);
      do_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 0);
      do_op("bp",       16'hA5A5, 16'h5A5A, 1'b0, 3);
      do_op("after_bp", 16'h0F0F, 16'h00F1, 1'b0, 0);

      // Abort mid-calculation: accept, let two slices complete, then reset.
      in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_sum", sum, 16'h0);
      check("abort_cc", cc, 4'h0);
      check("abort_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op("post_rst", 16'h8000, 16'h8000, 1'b0, 0);

      for (int i = 0; i < 6; i++)
         do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), i % 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
